// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_unit
// Description : Instruction fetch stage. Holds the PC, fetches one instruction
//               over a req/ack handshake and computes the next PC on retire.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        retire,
    input  logic        branch,
    input  logic        bne,
    input  logic        jmp,
    input  logic        zero,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    localparam int                   c_WAIT_W    = $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         r_instr;
    logic                r_err;
    logic [31:0]         r_count;
    logic [c_WAIT_W-1:0] r_wait;

    logic                w_accept;
    logic                w_timeout;
    logic                w_retire;
    logic [31:0]         w_p4;
    logic [31:0]         w_br_target;
    logic [31:0]         w_jmp_target;
    logic                w_taken;
    logic [31:0]         w_next_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_VALID;
                end else if (r_wait == c_WAIT_LAST) begin
                    // Give up for one cycle, then retry the same address.
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_VALID: begin
                if (retire) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Jump takes priority over a taken branch.
    always_comb begin
        w_p4         = r_pc + 32'd4;
        w_taken      = branch & (bne ? ~zero : zero);
        w_jmp_target = {w_p4[31:28], r_instr[25:0], 2'b00};
        w_br_target  = w_p4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        if (jmp) begin
            w_next_pc = w_jmp_target;
        end else if (w_taken) begin
            w_next_pc = w_br_target;
        end else begin
            w_next_pc = w_p4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_err   <= 1'b0;
            r_count <= 32'd0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_instr <= imem_rdata;
            end
            if ((r_state == S_REQ) && !imem_ack && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign instr_valid = (r_state == S_VALID);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign fetch_err   = r_err;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_unit
// Description : Self-checking bench: directed PC-sequencing table, timeout and
//               reset corner cases, then randomized fetch/retire traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        retire = 1'b0;
    logic        branch = 1'b0;
    logic        bne = 1'b0;
    logic        jmp = 1'b0;
    logic        zero = 1'b0;
    logic        fetch_err;
    logic [31:0] instr_count;

    mips_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .retire(retire), .branch(branch), .bne(bne), .jmp(jmp), .zero(zero),
        .fetch_err(fetch_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc;
    logic [31:0] mcount;
    logic        merr;

    typedef struct {
        logic [31:0] rdata;
        logic        br, bn, jm, zr;
        logic [31:0] nxt;
    } vec_t;
    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic br, input logic bn,
                                               input logic jm, input logic zr);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        if (jm) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br && (bn ? !zr : zr)) return seq + 32'(off);
        return seq;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_arrives", imem_req, 1);
    endtask

    task automatic fetch(input logic [31:0] rdata, input int delay);
        wait_req();
        chk("imem_addr", imem_addr, mpc);
        for (int d = 0; d < delay; d++) begin
            retire = 1'($urandom);
            tick();
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, mpc);
        end
        retire     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("instr_valid", instr_valid, 1);
        chk("instr", instr, rdata);
        chk("pc", pc, mpc);
        chk("req_low_in_valid", imem_req, 0);
        chk("fetch_err", fetch_err, merr);
    endtask

    task automatic retire_instr(input logic br, input logic bn, input logic jm, input logic zr,
                                input logic [31:0] exp_next, input int hold);
        for (int h = 0; h < hold; h++) begin
            branch = 1'($urandom); bne = 1'($urandom); jmp = 1'($urandom); zero = 1'($urandom);
            tick();
            chk("valid_hold", instr_valid, 1);
            chk("pc_hold", pc, mpc);
        end
        branch = br; bne = bn; jmp = jm; zero = zr; retire = 1'b1;
        tick();
        retire = 1'b0;
        branch = 1'($urandom); bne = 1'($urandom); jmp = 1'($urandom); zero = 1'($urandom);
        mcount = mcount + 32'd1;
        mpc    = exp_next;
        chk("next_addr", imem_addr, mpc);
        chk("req_after_retire", imem_req, 1);
        chk("valid_after_retire", instr_valid, 0);
        chk("instr_count", instr_count, mcount);
    endtask

    initial begin
        tbl[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        tbl[1]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        tbl[2]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0008};
        tbl[3]  = '{32'h1400_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C};
        tbl[4]  = '{32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        tbl[5]  = '{32'h1400_0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0144};
        tbl[6]  = '{32'h0BFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0FFF_FFFC};
        tbl[7]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000};
        tbl[8]  = '{32'h1000_8000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0FFE_0004};
        tbl[9]  = '{32'h0800_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[10] = '{32'h1400_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

        mpc = RST_PC; mcount = 32'd0; merr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", fetch_err, 0);
        chk("rst_count", instr_count, 32'd0);
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, RST_PC);

        for (int i = 0; i < 12; i++) begin
            fetch(tbl[i].rdata, i % 3);
            retire_instr(tbl[i].br, tbl[i].bn, tbl[i].jm, tbl[i].zr, tbl[i].nxt, i % 2);
        end

        // Fetch timeout: withhold ack for TO cycles, then one idle cycle and retry.
        wait_req();
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk("to_req_hold", imem_req, 1);
        end
        tick();
        chk("to_req_drop", imem_req, 0);
        chk("to_err_set", fetch_err, 1);
        merr = 1'b1;
        tick();
        chk("to_retry_req", imem_req, 1);
        chk("to_retry_addr", imem_addr, mpc);
        fetch(32'h2008_0005, 2);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, mpc + 32'd4, 0);

        // Reset during VALID with a stray ack in the same cycle.
        fetch(32'h1234_5678, 1);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        reset    = 1'b0;
        imem_ack = 1'b0;
        chk("rv_valid", instr_valid, 0);
        chk("rv_req", imem_req, 0);
        chk("rv_pc", pc, RST_PC);
        chk("rv_instr", instr, 32'd0);
        chk("rv_count", instr_count, 32'd0);
        chk("rv_err", fetch_err, 0);
        mpc = RST_PC; mcount = 32'd0; merr = 1'b0;
        tick();
        chk("rv_restart_req", imem_req, 1);
        chk("rv_restart_addr", imem_addr, RST_PC);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            logic        rb, rn, rj, rz;
            r  = $urandom;
            rb = ($urandom_range(0, 1) == 1);
            rn = 1'($urandom);
            rj = ($urandom_range(0, 3) == 0);
            rz = 1'($urandom);
            fetch(r, $urandom_range(0, TO - 1));
            retire_instr(rb, rn, rj, rz, model_next(mpc, r, rb, rn, rj, rz), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
